// File: rtl/mc_dp_pkg.sv
// mc_dp_pkg: opcodes, state encoding, field widths and flag update rule for mc_data_path.
// MC_DATA_PATH_MUL_EN makes opcode 9 (MUL) legal.
package mc_dp_pkg;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

    localparam int OP_W  = 4;
    localparam int IMM_W = 8;

    localparam logic [3:0] OP_MOVB = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_JUMP = 4'd5;
    localparam logic [3:0] OP_BZ   = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;

`ifdef MC_DATA_PATH_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    function automatic logic sets_flags(input logic [3:0] op);
        return (op >= OP_ADD && op <= OP_OR) || op == OP_XOR || (MUL_EN && op == OP_MUL);
    endfunction

    function automatic logic writes_rd(input logic [3:0] op);
        return op == OP_MOVB || sets_flags(op);
    endfunction

    function automatic logic legal_op(input logic [3:0] op);
        return op <= OP_XOR || (MUL_EN && op == OP_MUL);
    endfunction

    function automatic logic [1:0] next_flags(input logic [3:0] op, input logic rz, rc, z, c);
        return sets_flags(op) ? {rz, rc} : {z, c};
    endfunction
endpackage

// File: rtl/mc_dp_alu.sv
// mc_dp_alu: combinational ALU for mc_data_path; MUL path present under MC_DATA_PATH_MUL_EN.
module mc_dp_alu import mc_dp_pkg::*; #(
    parameter int DW = 16
) (
    input  logic [3:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] res,
    output logic          z,
    output logic          c
);
    logic [DW:0] sum, dif;
    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};
`ifdef MC_DATA_PATH_MUL_EN
    logic [2*DW-1:0] prod;
    assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
`endif
    // MOVB arrives with the immediate already on b, so pass-through is the default
    always_comb begin
        res = b;
        c = 1'b0;
        case (op)
            OP_ADD: {c, res} = sum;
            OP_SUB: {c, res} = dif;
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
`ifdef MC_DATA_PATH_MUL_EN
            OP_MUL: begin
                res = prod[DW-1:0];
                c = |prod[2*DW-1:DW];
            end
`endif
            default: ;
        endcase
    end
    assign z = res == '0;
endmodule

// File: rtl/mc_data_path.sv
// mc_data_path: multi-cycle fetch/decode/execute/writeback core over an NREG x DW register file.
// MC_DATA_PATH_MUL_EN adds opcode 9 (MUL) with a two-cycle EXEC.
module mc_data_path import mc_dp_pkg::*; #(
    parameter int DW = 16,
    parameter int PCW = 16,
    parameter int NREG = 4,
    localparam int RA = $clog2(NREG),
    localparam int IW = OP_W + 2 * RA + IMM_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    output logic           ins_req,
    output logic [PCW-1:0] ins_addr,
    input  logic           ins_ack,
    input  logic [IW-1:0]  ins_data,
    output logic [PCW-1:0] pc_out,
    output logic           en_out,
    output logic           zero,
    output logic           carry,
    output logic           halted,
    output logic           illegal,
    input  logic [RA-1:0]  dbg_sel,
    output logic [DW-1:0]  dbg_data
);
    state_t state, nxt;
    logic [IW-1:0] ir;
    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] a, b, res, alu_res;
    logic [PCW-1:0] pc, pcn, pc_rel;
    logic z, c, ill, zn, cn, alu_z, alu_c, mph, mul_wait;
    logic [3:0] op;
    logic [RA-1:0] rd, rs;
    logic [IMM_W-1:0] imm;

    assign op = ir[IW-1 -: OP_W];
    assign rd = ir[IW-OP_W-1 -: RA];
    assign rs = ir[IW-OP_W-RA-1 -: RA];
    assign imm = ir[IMM_W-1:0];
    assign pc_rel = pc + PCW'($signed(imm));
    assign mul_wait = MUL_EN && op == OP_MUL && !mph;

    assign ins_req = state == S_FETCH;
    assign ins_addr = pc;
    assign pc_out = pc;
    assign en_out = state == S_WB;
    assign halted = state == S_HALT;
    assign zero = z;
    assign carry = c;
    assign illegal = ill;
    assign dbg_data = regs[dbg_sel];

    mc_dp_alu #(.DW(DW)) u_alu (.op(op), .a(a), .b(b), .res(alu_res), .z(alu_z), .c(alu_c));

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   nxt = run ? S_FETCH : S_IDLE;
            S_FETCH:  nxt = ins_ack ? S_DECODE : S_FETCH;
            S_DECODE: nxt = S_EXEC;
            S_EXEC:   nxt = mul_wait ? S_EXEC : S_WB;
            S_WB:     nxt = op == OP_HALT ? S_HALT : run ? S_FETCH : S_IDLE;
            default:  nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pc <= '0;
            pcn <= '0;
            z <= 1'b0;
            c <= 1'b0;
            zn <= 1'b0;
            cn <= 1'b0;
            ill <= 1'b0;
            mph <= 1'b0;
            ir <= '0;
            a <= '0;
            b <= '0;
            res <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            state <= nxt;
            case (state)
                S_FETCH: if (ins_ack) ir <= ins_data;
                S_DECODE: begin
                    a <= regs[rd];
                    b <= op == OP_MOVB ? DW'(imm) : regs[rs];
                end
                S_EXEC: begin
                    mph <= mul_wait;
                    res <= alu_res;
                    {zn, cn} <= next_flags(op, alu_z, alu_c, z, c);
                    pcn <= (op == OP_JUMP || (op == OP_BZ && z)) ? pc_rel : op == OP_HALT ? pc : pc + PCW'(1);
                end
                S_WB: begin
                    if (writes_rd(op)) regs[rd] <= res;
                    pc <= pcn;
                    z <= zn;
                    c <= cn;
                    ill <= ill | !legal_op(op);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_data_path.sv
// tb_mc_data_path: scoreboard bench; expectations pushed at fetch handshake, checked after each retire.
module tb_mc_data_path;
    logic clk = 1'b0, rst = 1'b1, run = 1'b0, ins_ack = 1'b0;
    logic [15:0] ins_data = '0;
    logic [1:0] dbg_sel = '0;
    logic ins_req, en_out, zero, carry, halted, illegal;
    logic [15:0] ins_addr, pc_out, dbg_data;

`ifdef MC_DATA_PATH_MUL_EN
    localparam bit MUL = 1'b1;
`else
    localparam bit MUL = 1'b0;
`endif

    mc_data_path dut (
        .clk(clk), .rst(rst), .run(run), .ins_req(ins_req), .ins_addr(ins_addr),
        .ins_ack(ins_ack), .ins_data(ins_data), .pc_out(pc_out), .en_out(en_out),
        .zero(zero), .carry(carry), .halted(halted), .illegal(illegal),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  rd;
        logic [15:0] val;
        logic [15:0] pc;
        logic        z;
        logic        c;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    logic [15:0] mr [4];
    logic [15:0] mpc;
    logic mz, mcy, mill;
    int total = 0, bad = 0, cyc = 0, en_cnt = 0, last_en = 0, prev_en = 0, req_cyc = 0, nexp = 0;
    exp_t cur;
    logic pend = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mr[i] = '0;
        mpc = '0;
        mz = 1'b0;
        mcy = 1'b0;
        mill = 1'b0;
    endtask

    task automatic model_push(input logic [15:0] ins);
        logic [3:0] op;
        logic [1:0] rd, rs;
        logic [7:0] imm;
        logic [15:0] a, b, npc, sx;
        logic [16:0] s;
        logic [31:0] p;
        exp_t e;
        op = ins[15:12];
        rd = ins[11:10];
        rs = ins[9:8];
        imm = ins[7:0];
        a = mr[rd];
        b = mr[rs];
        sx = {{8{imm[7]}}, imm};
        npc = mpc + 16'd1;
        case (op)
            4'd0: mr[rd] = {8'h00, imm};
            4'd1: begin s = {1'b0, a} + {1'b0, b}; mr[rd] = s[15:0]; mcy = s[16]; mz = mr[rd] == 16'h0; end
            4'd2: begin mr[rd] = a - b; mcy = a < b; mz = mr[rd] == 16'h0; end
            4'd3: begin mr[rd] = a & b; mcy = 1'b0; mz = mr[rd] == 16'h0; end
            4'd4: begin mr[rd] = a | b; mcy = 1'b0; mz = mr[rd] == 16'h0; end
            4'd8: begin mr[rd] = a ^ b; mcy = 1'b0; mz = mr[rd] == 16'h0; end
            4'd5: npc = mpc + sx;
            4'd6: if (mz) npc = mpc + sx;
            4'd7: npc = mpc;
            4'd9: if (MUL) begin
                    p = a * b;
                    mr[rd] = p[15:0];
                    mcy = |p[31:16];
                    mz = mr[rd] == 16'h0;
                end else mill = 1'b1;
            default: mill = 1'b1;
        endcase
        mpc = npc;
        e = '{rd: rd, val: mr[rd], pc: mpc, z: mz, c: mcy, ill: mill};
        sb.push_back(e);
        nexp++;
    endtask

    // register writes become visible the cycle after WB, so compare one negedge after en_out
    always @(negedge clk) begin
        if (pend) begin
            pend = 1'b0;
            check("rd_val", dbg_data, cur.val);
            check("pc", pc_out, cur.pc);
            check("zero", zero, cur.z);
            check("carry", carry, cur.c);
            check("illegal", illegal, cur.ill);
        end
        if (en_out) begin
            en_cnt++;
            prev_en = last_en;
            last_en = cyc;
            check("sb_depth", sb.size(), 1);
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                dbg_sel = cur.rd;
                pend = 1'b1;
            end
        end
    end

    task automatic wait_req();
        int n = 0;
        while (!ins_req && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", ins_req, 1);
    endtask

    task automatic exec_ins(input logic [15:0] ins, input int delay);
        wait_req();
        req_cyc = cyc;
        check("fetch_addr", ins_addr, mpc);
        repeat (delay) begin
            ins_ack = 1'b0;
            @(negedge clk);
            check("req_hold", ins_req, 1);
        end
        ins_ack = 1'b1;
        ins_data = ins;
        model_push(ins);
        @(negedge clk);
        ins_ack = 1'b0;
        ins_data = 16'($urandom);
    endtask

    task automatic wait_done();
        int k = 0;
        while ((en_cnt < nexp || pend) && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("retire", en_cnt, nexp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ec;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_req", ins_req, 0);
        check("rst_en", en_out, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", pc_out, 0);
        check("rst_flags", {zero, carry, illegal}, 0);
        check("rst_r0", dbg_data, 0);

        rst = 1'b0;
        run = 1'b1;
        @(negedge clk);
        check("req_after_idle", ins_req, 1);
        exec_ins(enc(4'd0, 2'd0, 2'd0, 8'h01), 0);
        wait_done();
        check("latency", last_en - req_cyc, 3);

        exec_ins(enc(4'd2, 2'd1, 2'd0, 8'h00), 0);
        exec_ins(enc(4'd1, 2'd1, 2'd0, 8'h00), 0);
        wait_done();
        check("period4", last_en - prev_en, 4);
        exec_ins(enc(4'd3, 2'd2, 2'd0, 8'h00), 0);
        exec_ins(enc(4'd4, 2'd2, 2'd0, 8'h00), 3);
        wait_done();
        check("period_wait3", last_en - prev_en, 7);

        exec_ins(enc(4'd5, 2'd0, 2'd0, 8'h78), 0);
        exec_ins(enc(4'd8, 2'd3, 2'd0, 8'h00), 0);
        exec_ins(enc(4'd6, 2'd0, 2'd0, 8'h10), 0);
        exec_ins(enc(4'd0, 2'd3, 2'd0, 8'hAB), 0);
        exec_ins(enc(4'd0, 2'd2, 2'd0, 8'h80), 0);
        exec_ins(enc(4'd1, 2'd2, 2'd2, 8'h00), 0);
        exec_ins(enc(4'd9, 2'd2, 2'd2, 8'h00), 0);
        wait_done();
        check("period_op9", last_en - prev_en, MUL ? 5 : 4);
        exec_ins(enc(4'hF, 2'd1, 2'd1, 8'h00), 0);

        exec_ins(enc(4'd0, 2'd1, 2'd0, 8'h33), 0);
        run = 1'b0;
        wait_done();
        repeat (6) begin
            @(negedge clk);
            check("idle_no_req", ins_req, 0);
        end
        run = 1'b1;
        exec_ins(enc(4'd0, 2'd0, 2'd0, 8'h44), 0);
        wait_done();

        ec = en_cnt;
        exec_ins(enc(4'd0, 2'd3, 2'd0, 8'h55), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_req", ins_req, 0);
        check("mid_rst_pc", pc_out, 0);
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        nexp--;
        model_reset();
        check("mid_rst_ill", illegal, 0);
        check("mid_rst_dbg", dbg_data, 0);
        check("mid_rst_no_wb", en_cnt, ec);
        @(negedge clk);
        check("rst_restart_req", ins_req, 1);

        exec_ins(enc(4'd0, 2'd0, 2'd0, 8'h02), 0);
        exec_ins(enc(4'd5, 2'd0, 2'd0, 8'hFE), 0);
        exec_ins(enc(4'd0, 2'd1, 2'd0, 8'h07), 0);
        exec_ins(enc(4'd7, 2'd0, 2'd0, 8'h00), 0);
        wait_done();
        repeat (8) begin
            @(negedge clk);
            check("halt_no_req", ins_req, 0);
        end
        check("halted", halted, 1);
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
